// File: rtl/acc_alu.sv
// acc_alu: accumulator datapath -- ACC register, 4-op ALU, registered zero flag,
// sticky illegal-select flag and a combinational system-bus drive path.
// Optional build macro ACC_ALU_FLAGS_EN adds registered carry/borrow (c_flag)
// and sign (n_flag) outputs that update together with acc_q.
module acc_alu #(
   parameter int WORD_W = 10
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              load_ACC,
   input  logic              ALU_ACC,
   input  logic              ALU_add,
   input  logic              ALU_sub,
   input  logic              ALU_xor,
   input  logic              ALU_xnor,
   input  logic              ACC_bus,
   input  logic [WORD_W-1:0] sysbus_in,
   output logic [WORD_W-1:0] sysbus_out,
   output logic              sysbus_drive,
   output logic [WORD_W-1:0] acc_q,
   output logic              z_flag,
`ifdef ACC_ALU_FLAGS_EN
   output logic              c_flag,
   output logic              n_flag,
`endif
   output logic              op_error
);

   logic [WORD_W-1:0] alu_res;
   logic [WORD_W-1:0] acc_d;
   logic              z_q, z_d;
   logic              op_err_q, op_err_d;
   logic              multi_sel;
`ifdef ACC_ALU_FLAGS_EN
   logic [WORD_W:0]   sum_w;
   logic              alu_c;
   logic              c_q, c_d;
   logic              n_q, n_d;
`endif

   // ALU: fixed priority add > sub > xor > xnor, pass-through of the bus when idle
   always_comb begin
      alu_res = sysbus_in;
      if (ALU_add)       alu_res = acc_q + sysbus_in;
      else if (ALU_sub)  alu_res = acc_q - sysbus_in;
      else if (ALU_xor)  alu_res = acc_q ^ sysbus_in;
      else if (ALU_xnor) alu_res = ~(acc_q ^ sysbus_in);
   end

`ifdef ACC_ALU_FLAGS_EN
   // Carry-out of add / borrow of sub; logic ops and bus pass-through clear it
   always_comb begin
      sum_w = {1'b0, acc_q} + {1'b0, sysbus_in};
      alu_c = 1'b0;
      if (ALU_add)      alu_c = sum_w[WORD_W];
      else if (ALU_sub) alu_c = (acc_q < sysbus_in);
   end
`endif

   // More than one op select is a sequencer bug; flagged but the priority result is still used
   assign multi_sel = (ALU_add & (ALU_sub | ALU_xor | ALU_xnor)) |
                      (ALU_sub & (ALU_xor | ALU_xnor)) |
                      (ALU_xor & ALU_xnor);

   // Next-state: everything holds unless load_ACC; zero flag tracks the value being loaded
   always_comb begin
      acc_d    = acc_q;
      z_d      = z_q;
      op_err_d = op_err_q;
`ifdef ACC_ALU_FLAGS_EN
      c_d      = c_q;
      n_d      = n_q;
`endif
      if (load_ACC) begin
         acc_d = ALU_ACC ? alu_res : sysbus_in;
         z_d   = (acc_d == '0);
         if (ALU_ACC && multi_sel) op_err_d = 1'b1;
`ifdef ACC_ALU_FLAGS_EN
         c_d   = ALU_ACC ? alu_c : 1'b0;
         n_d   = acc_d[WORD_W-1];
`endif
      end
   end

   // State registers; async reset leaves ACC zero, so z_flag resets high
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         acc_q    <= '0;
         z_q      <= 1'b1;
         op_err_q <= 1'b0;
`ifdef ACC_ALU_FLAGS_EN
         c_q      <= 1'b0;
         n_q      <= 1'b0;
`endif
      end else begin
         acc_q    <= acc_d;
         z_q      <= z_d;
         op_err_q <= op_err_d;
`ifdef ACC_ALU_FLAGS_EN
         c_q      <= c_d;
         n_q      <= n_d;
`endif
      end
   end

   // Bus drive is same-cycle so the sequencer can store ACC to MDR in one state
   assign sysbus_out   = ACC_bus ? acc_q : '0;
   assign sysbus_drive = ACC_bus;
   assign z_flag       = z_q;
   assign op_error     = op_err_q;
`ifdef ACC_ALU_FLAGS_EN
   assign c_flag       = c_q;
   assign n_flag       = n_q;
`endif

endmodule

// File: tb/tb_acc_alu.sv
// tb_acc_alu: directed vectors with hand-computed expectations for acc_alu (WORD_W=10).
// Flag checks are compiled in only when ACC_ALU_FLAGS_EN is defined.
module tb_acc_alu;
   localparam int W = 10;

   logic clock = 1'b0;
   logic n_reset;
   logic load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor, ACC_bus;
   logic [W-1:0] sysbus_in, sysbus_out, acc_q;
   logic sysbus_drive, z_flag, op_error;
`ifdef ACC_ALU_FLAGS_EN
   logic c_flag, n_flag;
`endif

   int n_chk = 0;
   int n_err = 0;

   acc_alu #(.WORD_W(W)) dut (
      .clock(clock), .n_reset(n_reset),
      .load_ACC(load_ACC), .ALU_ACC(ALU_ACC),
      .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_xor(ALU_xor), .ALU_xnor(ALU_xnor),
      .ACC_bus(ACC_bus), .sysbus_in(sysbus_in),
      .sysbus_out(sysbus_out), .sysbus_drive(sysbus_drive),
      .acc_q(acc_q), .z_flag(z_flag),
`ifdef ACC_ALU_FLAGS_EN
      .c_flag(c_flag), .n_flag(n_flag),
`endif
      .op_error(op_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // drive one control vector (sampled at next rising edge)
   task automatic drv(input logic ld, input logic aa, input logic [3:0] ops, input logic [W-1:0] bus);
      load_ACC  = ld;
      ALU_ACC   = aa;
      {ALU_add, ALU_sub, ALU_xor, ALU_xnor} = ops;
      sysbus_in = bus;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic c, input logic n);
`ifdef ACC_ALU_FLAGS_EN
      chk({tag, ".c"}, {31'b0, c_flag}, {31'b0, c});
      chk({tag, ".n"}, {31'b0, n_flag}, {31'b0, n});
`else
      if (c === 1'bx || n === 1'bx) $display("note: bad flag expectation in %s", tag);
`endif
   endtask

   localparam logic [3:0] OP_NONE = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_XNOR = 4'b0001;

   initial begin
      n_reset = 1'b0;
      ACC_bus = 1'b0;
      drv(1'b0, 1'b0, OP_NONE, '0);
      #12;
      chk("rst.acc", 32'(acc_q), 32'h000);
      chk("rst.z",   32'(z_flag), 32'h1);
      chk("rst.err", 32'(op_error), 32'h0);
      chk("rst.out", 32'(sysbus_out), 32'h000);
      chk("rst.drv", 32'(sysbus_drive), 32'h0);
      chk_flags("rst", 1'b0, 1'b0);
      n_reset = 1'b1;

      // bus load
      drv(1'b1, 1'b0, OP_NONE, 10'h155);
      tick();
      chk("ld.acc", 32'(acc_q), 32'h155);
      chk("ld.z",   32'(z_flag), 32'h0);
      chk_flags("ld", 1'b0, 1'b0);

      // async reset mid-cycle with load pending
      #2 n_reset = 1'b0;
      #1;
      chk("arst.acc", 32'(acc_q), 32'h000);
      chk("arst.z",   32'(z_flag), 32'h1);
      chk("arst.err", 32'(op_error), 32'h0);
      @(negedge clock);
      n_reset = 1'b1;
      tick();
      chk("reld.acc", 32'(acc_q), 32'h155);

      // add: 0x155 + 0x0AB = 0x200
      drv(1'b1, 1'b1, OP_ADD, 10'h0AB);
      tick();
      chk("add.acc", 32'(acc_q), 32'h200);
      chk("add.z",   32'(z_flag), 32'h0);
      chk_flags("add", 1'b0, 1'b1);

      // sub with borrow: 0x200 - 0x201 = 0x3FF
      drv(1'b1, 1'b1, OP_SUB, 10'h201);
      tick();
      chk("sub.acc", 32'(acc_q), 32'h3FF);
      chk("sub.z",   32'(z_flag), 32'h0);
      chk_flags("sub", 1'b1, 1'b1);

      // xor to zero
      drv(1'b1, 1'b1, OP_XOR, 10'h3FF);
      tick();
      chk("xor.acc", 32'(acc_q), 32'h000);
      chk("xor.z",   32'(z_flag), 32'h1);
      chk_flags("xor", 1'b0, 1'b0);

      // xnor of zeros -> all ones
      drv(1'b1, 1'b1, OP_XNOR, 10'h000);
      tick();
      chk("xnor.acc", 32'(acc_q), 32'h3FF);
      chk("xnor.z",   32'(z_flag), 32'h0);
      chk_flags("xnor", 1'b0, 1'b1);

      // add wrap with carry: 0x3FF + 0x002 = 0x001
      drv(1'b1, 1'b1, OP_ADD, 10'h002);
      tick();
      chk("wrap.acc", 32'(acc_q), 32'h001);
      chk_flags("wrap", 1'b1, 1'b0);

      // ALU_ACC with no select passes the bus
      drv(1'b1, 1'b1, OP_NONE, 10'h3F0);
      tick();
      chk("pass.acc", 32'(acc_q), 32'h3F0);
      chk_flags("pass", 1'b0, 1'b1);

      // load_ACC=0 holds everything, selects ignored
      drv(1'b0, 1'b1, 4'b1100, 10'h001);
      tick();
      tick();
      chk("hold.acc", 32'(acc_q), 32'h3F0);
      chk("hold.z",   32'(z_flag), 32'h0);
      chk("hold.err", 32'(op_error), 32'h0);
      chk_flags("hold", 1'b0, 1'b1);

      // bus drive is combinational
      ACC_bus = 1'b1;
      #1;
      chk("bus.out", 32'(sysbus_out), 32'h3F0);
      chk("bus.drv", 32'(sysbus_drive), 32'h1);
      ACC_bus = 1'b0;
      #1;
      chk("nobus.out", 32'(sysbus_out), 32'h000);
      chk("nobus.drv", 32'(sysbus_drive), 32'h0);

      // simultaneous drive and bus load; multi-select without ALU_ACC is not an error
      ACC_bus = 1'b1;
      drv(1'b1, 1'b0, 4'b1100, 10'h001);
      #1;
      chk("sim.old", 32'(sysbus_out), 32'h3F0);
      tick();
      chk("sim.new", 32'(sysbus_out), 32'h001);
      chk("sim.err", 32'(op_error), 32'h0);
      ACC_bus = 1'b0;

      // illegal multi-select: add wins, sticky error
      drv(1'b1, 1'b1, 4'b1010, 10'h001);
      tick();
      chk("multi.acc", 32'(acc_q), 32'h002);
      chk("multi.err", 32'(op_error), 32'h1);
      drv(1'b1, 1'b1, OP_SUB, 10'h002);
      tick();
      tick();
      chk("sticky.acc", 32'(acc_q), 32'h3FE);
      chk("sticky.err", 32'(op_error), 32'h1);

      // only reset clears it
      drv(1'b0, 1'b0, OP_NONE, '0);
      #2 n_reset = 1'b0;
      #1;
      chk("clr.err", 32'(op_error), 32'h0);
      chk("clr.acc", 32'(acc_q), 32'h000);
      chk("clr.z",   32'(z_flag), 32'h1);
      chk_flags("clr", 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
